// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART-driven ALU front end: ASCII codes, ALU opcodes,
// parser state encoding and the operator-character decode.
package uart_alu_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SLL = 6'b000000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_A,
        ST_ACC_B,
        ST_GET_OP,
        ST_WAIT_EOL,
        ST_ISSUE,
        ST_DRAIN
    } parse_state_t;

    typedef struct packed {
        logic       hit;
        logic [5:0] code;
    } op_map_t;

    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
    endfunction

    function automatic logic is_eol(input logic [7:0] ch);
        return (ch == ASCII_CR) || (ch == ASCII_LF);
    endfunction

    function automatic op_map_t decode_op(input logic [7:0] ch);
        op_map_t m;
        m.hit  = 1'b1;
        m.code = OP_ADD;
        case (ch)
            8'h2B:   m.code = OP_ADD;   // '+'
            8'h2D:   m.code = OP_SUB;   // '-'
            8'h26:   m.code = OP_AND;   // '&'
            8'h7C:   m.code = OP_OR;    // '|'
            8'h5E:   m.code = OP_XOR;   // '^'
            8'h7E:   m.code = OP_NOR;   // '~'
            8'h3E:   m.code = OP_SRA;   // '>'
            8'h3C:   m.code = OP_SLL;   // '<'
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/dec_accumulator.sv
// Decimal digit accumulator: value = value*10 + digit, with a sticky overflow flag
// that also reports combinationally on the digit that first overflows.
module dec_accumulator
    import uart_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load_digit,
    input  logic [3:0]        digit,
    output logic [DATA_W-1:0] value,
    output logic              ovf
);

    logic [DATA_W-1:0] value_q;
    logic              ovf_q;
    logic [DATA_W+3:0] acc_wide;
    logic [DATA_W+3:0] next_wide;
    logic              carry;

    // x*10 as (x<<3)+(x<<1); four guard bits hold any product of a DATA_W value
    assign acc_wide  = {4'b0000, value_q};
    assign next_wide = (acc_wide << 3) + (acc_wide << 1) + {{DATA_W{1'b0}}, digit};
    assign carry     = |next_wide[DATA_W+3:DATA_W];

    assign value = value_q;
    assign ovf   = ovf_q | (load_digit & carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            value_q <= '0;
            ovf_q   <= 1'b0;
        end else if (load_digit) begin
            value_q <= next_wide[DATA_W-1:0];
            ovf_q   <= ovf_q | carry;
        end
    end

endmodule

// File: rtl/ascii_operand_parser.sv
// Parses "<A> <B> <op><CR|LF>" from UART RX bytes and issues operands/opcode to the
// ALU with a one-cycle alu_valid once the downstream sender is ready.
module ascii_operand_parser
    import uart_alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int OP_W       = 6,
    parameter int MAX_DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              dst_ready,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    output logic [OP_W-1:0]   opcode,
    output logic              alu_valid,
    output logic              parse_error
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    parse_state_t      state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] acc_value;
    logic              acc_ovf;
    logic              acc_clear, acc_load;
    logic              latch_a, latch_b, latch_op;
    logic              cnt_inc, cnt_clr;
    logic              err, issue;
    logic [DATA_W-1:0] shadow_a, shadow_b;
    logic [OP_W-1:0]   shadow_op;
    op_map_t           op_map;
    logic              rx_digit, rx_space, rx_eol;

    assign rx_digit = is_digit(rx_data);
    assign rx_space = (rx_data == ASCII_SPACE);
    assign rx_eol   = is_eol(rx_data);
    assign op_map   = decode_op(rx_data);

    dec_accumulator #(.DATA_W(DATA_W)) u_acc (
        .clk        (clk),
        .rst        (rst),
        .clear      (acc_clear),
        .load_digit (acc_load),
        .digit      (rx_data[3:0]),
        .value      (acc_value),
        .ovf        (acc_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        acc_clear  = 1'b0;
        acc_load   = 1'b0;
        latch_a    = 1'b0;
        latch_b    = 1'b0;
        latch_op   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        err        = 1'b0;
        issue      = 1'b0;
        case (state)
            ST_IDLE: if (rx_done) begin
                if (rx_digit) begin
                    acc_load   = 1'b1;
                    cnt_inc    = 1'b1;
                    state_next = ST_ACC_A;
                end else if (!(rx_space || rx_eol)) begin
                    err = 1'b1;
                end
            end
            ST_ACC_A, ST_ACC_B: if (rx_done) begin
                // The digit is always loaded; a resulting overflow or excess count aborts the frame
                if (rx_digit) begin
                    acc_load = 1'b1;
                    cnt_inc  = 1'b1;
                    if (acc_ovf || cnt == CNT_W'(MAX_DIGITS)) err = 1'b1;
                end else if (rx_space && cnt != '0) begin
                    latch_a    = (state == ST_ACC_A);
                    latch_b    = (state == ST_ACC_B);
                    acc_clear  = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = (state == ST_ACC_A) ? ST_ACC_B : ST_GET_OP;
                end else begin
                    err = 1'b1;
                end
            end
            ST_GET_OP: if (rx_done) begin
                if (op_map.hit) begin
                    latch_op   = 1'b1;
                    state_next = ST_WAIT_EOL;
                end else begin
                    err = 1'b1;
                end
            end
            ST_WAIT_EOL: if (rx_done) begin
                if (rx_eol) state_next = ST_ISSUE;
                else        err        = 1'b1;
            end
            ST_ISSUE: if (dst_ready) begin
                issue      = 1'b1;
                state_next = ST_IDLE;
            end
            ST_DRAIN: if (rx_done && rx_eol) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (err) begin
            acc_clear  = 1'b1;
            cnt_clr    = 1'b1;
            state_next = rx_eol ? ST_IDLE : ST_DRAIN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            operand_a   <= '0;
            operand_b   <= '0;
            opcode      <= '0;
            alu_valid   <= 1'b0;
            parse_error <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;
            alu_valid   <= issue;
            parse_error <= err;
            if (issue) begin
                operand_a <= shadow_a;
                operand_b <= shadow_b;
                opcode    <= shadow_op;
            end
        end
    end

    // Shadow latches are only meaningful after a complete frame, so they carry no reset
    always_ff @(posedge clk) begin
        if (latch_a)  shadow_a  <= acc_value;
        if (latch_b)  shadow_b  <= acc_value;
        if (latch_op) shadow_op <= OP_W'(op_map.code);
    end

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Directed bench for ascii_operand_parser: table of frames plus hand-written
// latency, back-pressure and reset sequences.
module tb_ascii_operand_parser;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        dst_ready = 1'b1;
    logic [31:0] operand_a, operand_b;
    logic [5:0]  opcode;
    logic        alu_valid, parse_error;

    int n_cmp = 0;
    int n_bad = 0;
    int n_vld = 0;
    int n_err = 0;

    ascii_operand_parser #(.DATA_W(32), .OP_W(6), .MAX_DIGITS(10)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .dst_ready   (dst_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .opcode      (opcode),
        .alu_valid   (alu_valid),
        .parse_error (parse_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (alu_valid)   n_vld++;
        if (parse_error) n_err++;
    end

    typedef struct packed {
        logic        exp_vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
    } vec_t;

    localparam int NV = 13;
    string frames [NV];
    vec_t  vecs   [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] last_a, last_b;
    logic [5:0]  last_op;
    int          v0, e0;

    initial begin
        frames[0]  = "4294967295 1 -\n";
        vecs[0]    = '{1'b1, 32'hFFFF_FFFF, 32'd1, 6'b100010};
        frames[1]  = "4294967296 1 +\r";
        vecs[1]    = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[2]  = "5 x 3 +\r";
        vecs[2]    = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[3]  = "7 2 &\r";
        vecs[3]    = '{1'b1, 32'd7, 32'd2, 6'b100100};
        frames[4]  = "00000000001 2 +\r";
        vecs[4]    = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[5]  = "0 0 ~\n";
        vecs[5]    = '{1'b1, 32'd0, 32'd0, 6'b100111};
        frames[6]  = " 8 2 >\r";
        vecs[6]    = '{1'b1, 32'd8, 32'd2, 6'b000011};
        frames[7]  = "1 31 <\n";
        vecs[7]    = '{1'b1, 32'd1, 32'd31, 6'b000000};
        frames[8]  = "1  2 +\r";
        vecs[8]    = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[9]  = "3 4 ?\r";
        vecs[9]    = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[10] = "0000000001 4294967295 ^\r";
        vecs[10]   = '{1'b1, 32'd1, 32'hFFFF_FFFF, 6'b100110};
        frames[11] = "12\r";
        vecs[11]   = '{1'b0, 32'd0, 32'd0, 6'd0};
        frames[12] = "6 6 +x\r";
        vecs[12]   = '{1'b0, 32'd0, 32'd0, 6'd0};

        // Reset state
        idle(3);
        chk("reset_a", operand_a, 32'd0);
        chk("reset_b", operand_b, 32'd0);
        chk("reset_op", 32'(opcode), 32'd0);
        chk("reset_vld_err", {30'd0, alu_valid, parse_error}, 32'd0);
        rst = 1'b0;
        idle(2);

        // "12 30 +\r": exact issue latency relative to the CR strobe
        v0 = n_vld; e0 = n_err;
        send_str("12 30 +");
        @(negedge clk);
        rx_data = 8'h0D;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        chk("lat_edge1_vld", 32'(alu_valid), 32'd0);
        @(posedge clk); #1;
        chk("lat_edge2_vld", 32'(alu_valid), 32'd1);
        chk("t1_a", operand_a, 32'd12);
        chk("t1_b", operand_b, 32'd30);
        chk("t1_op", 32'(opcode), 32'(6'b100000));
        @(posedge clk); #1;
        chk("lat_edge3_vld", 32'(alu_valid), 32'd0);
        idle(3);
        chk("t1_vld_count", 32'(n_vld - v0), 32'd1);
        chk("t1_err_count", 32'(n_err - e0), 32'd0);
        last_a = 32'd12; last_b = 32'd30; last_op = 6'b100000;

        // Table of frames
        for (int i = 0; i < NV; i++) begin
            v0 = n_vld; e0 = n_err;
            send_str(frames[i]);
            idle(4);
            chk($sformatf("v%0d_vld_count", i), 32'(n_vld - v0), vecs[i].exp_vld ? 32'd1 : 32'd0);
            chk($sformatf("v%0d_err_count", i), 32'(n_err - e0), vecs[i].exp_vld ? 32'd0 : 32'd1);
            if (vecs[i].exp_vld) begin
                last_a = vecs[i].a; last_b = vecs[i].b; last_op = vecs[i].op;
            end
            chk($sformatf("v%0d_a", i), operand_a, last_a);
            chk($sformatf("v%0d_b", i), operand_b, last_b);
            chk($sformatf("v%0d_op", i), 32'(opcode), 32'(last_op));
        end

        // Back-pressure: frame held in ISSUE, extra bytes dropped
        v0 = n_vld; e0 = n_err;
        dst_ready = 1'b0;
        send_str("9 9 |\r");
        send_str("1 1 +\r");
        idle(50);
        chk("bp_held_vld", 32'(n_vld - v0), 32'd0);
        chk("bp_held_a", operand_a, last_a);
        chk("bp_held_op", 32'(opcode), 32'(last_op));
        dst_ready = 1'b1;
        idle(6);
        chk("bp_vld_count", 32'(n_vld - v0), 32'd1);
        chk("bp_err_count", 32'(n_err - e0), 32'd0);
        chk("bp_a", operand_a, 32'd9);
        chk("bp_b", operand_b, 32'd9);
        chk("bp_op", 32'(opcode), 32'(6'b100101));

        // Reset mid-frame
        v0 = n_vld; e0 = n_err;
        send_str("123 4");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_a", operand_a, 32'd0);
        chk("mid_rst_b", operand_b, 32'd0);
        chk("mid_rst_op", 32'(opcode), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_str("1 1 ^\r");
        idle(4);
        chk("post_rst_vld_count", 32'(n_vld - v0), 32'd1);
        chk("post_rst_err_count", 32'(n_err - e0), 32'd0);
        chk("post_rst_a", operand_a, 32'd1);
        chk("post_rst_b", operand_b, 32'd1);
        chk("post_rst_op", 32'(opcode), 32'(6'b100110));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
